mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles from the issue cycle to the data-valid cycle (legal 1..4).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have i_req in 1 (fetch request), i_addr in 32 (fetch byte address), i_gnt out 1 (fetch accepted), i_rvalid out 1, i_rdata out 32.
REQ-005 SHALL have d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_gnt out 1, d_rvalid out 1 (read data or write ack), d_rdata out 32.
REQ-006 SHALL have mem_en out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_rdata in 32; one shared single-port memory, writes on the clk edge ending the issue cycle.

Function
REQ-007 SHALL use FSM states IDLE, WAIT, RESP; only one transaction outstanding.
REQ-008 SHALL, in IDLE with any request, grant exactly one requester in that same cycle: x_gnt=1, mem_en=1, mem_addr/mem_we/mem_wdata muxed combinationally from the winner.
REQ-009 SHALL drive mem_addr[1:0]=2'b00; mem_we=0 for fetch grants; mem_we=d_we for data grants.
REQ-010 SHALL transition IDLE->RESP when MEM_LAT=1, else IDLE->WAIT loading a down-counter with MEM_LAT-2; WAIT->RESP when counter is 0, else decrement.
REQ-011 SHALL, in RESP, pulse x_rvalid for the granted requester only, with x_rdata=mem_rdata; rvalid occurs exactly MEM_LAT cycles after gnt; RESP->IDLE unconditionally.
REQ-012 SHALL hold x_rdata at 0 whenever x_rvalid=0.
REQ-013 SHALL keep i_gnt, d_gnt, mem_en at 0 in WAIT and RESP; requesters hold req/addr/data stable until gnt.
REQ-014 SHALL, on simultaneous i_req and d_req in IDLE, pick the winner per REQ-019/REQ-020; loser stays pending, is served in the next IDLE cycle.
REQ-015 SHALL ignore a request dropped before gnt (no issue, no rvalid).
REQ-016 SHALL achieve back-to-back throughput of one transaction per MEM_LAT+1 cycles.

Reset
REQ-017 SHALL, on reset, set state IDLE, counter 0, last-served=I, and drive all gnt, rvalid, mem_en, mem_we to 0 and all rdata to 0 in the following cycle.
REQ-018 SHALL, on reset mid-transaction (WAIT or RESP), abandon it without rvalid; a write already issued is not undone.

Configuration
REQ-019 SHALL, with MEM_ARB_RR_EN defined, use round-robin on ties: winner is the requester not served last; last-served updates on every grant.
REQ-020 SHALL, without MEM_ARB_RR_EN, give data fixed priority on ties; last-served register absent.

Structure
REQ-021 SHALL place the state enum (IDLE, WAIT, RESP) and requester-id enum (REQ_I, REQ_D) in package mem_arb_pkg.
REQ-022 SHALL implement tie resolution in sub-module arb2_pick (two requests plus last-served in, one-hot grant out).

Verification
REQ-023 Fetch only, MEM_LAT=1, i_addr=0x10, RAM[4]=0xDEADBEEF -> i_gnt cycle T, mem_addr=0x10, i_rvalid cycle T+1, i_rdata=0xDEADBEEF.
REQ-024 Data write d_addr=0x23, d_wdata=0x12345678, then fetch 0x20 -> mem_addr=0x20 on write, d_rvalid ack, fetch returns 0x12345678.
REQ-025 Both requesting every cycle, fixed priority -> d_gnt every grant slot, i_gnt never while d_req high.
REQ-026 Both requesting, MEM_ARB_RR_EN -> grants alternate D,I,D,I starting with D after reset.
REQ-027 MEM_LAT=3, fetch grant cycle T -> WAIT cycles T+1..T+2, i_rvalid at T+3, next gnt no earlier than T+4.
REQ-028 Reset asserted in WAIT -> no rvalid, IDLE next cycle, new request granted immediately after reset release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the fetch/data memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch port, data port and shared memory port bundle
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/arb2_pick.sv
// rtl/arb2_pick.sv - two-way tie breaker; gnt[0]=fetch, gnt[1]=data
module arb2_pick
    import mem_arb_pkg::*;
(
    input  logic      req_i,
    input  logic      req_d,
    input  req_id_e   last,
    output logic [1:0] gnt
);

    // On a tie the side not served last wins; a constant last=REQ_I means data-first.
    always_comb begin
        gnt = 2'b00;
        if (req_i && req_d) begin
            gnt = (last == REQ_D) ? 2'b01 : 2'b10;
        end else if (req_d) begin
            gnt = 2'b10;
        end else if (req_i) begin
            gnt = 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding fetch/data arbiter onto one memory port (MEM_ARB_RR_EN: round-robin ties)
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [1:0] LAT_LOAD = (MEM_LAT >= 2) ? 2'(MEM_LAT - 2) : 2'd0;

    arb_state_e state, state_nxt;
    logic [1:0] cnt, cnt_nxt;
    req_id_e    owner, owner_nxt;
    req_id_e    last_sel;
    req_id_e    win;
    logic [1:0] gnt_oh;
    logic       issue;

    arb2_pick u_pick (
        .req_i (bus.i_req),
        .req_d (bus.d_req),
        .last  (last_sel),
        .gnt   (gnt_oh)
    );

    // Nothing is issued while reset is held so a reset cycle never touches memory.
    assign issue = (state == IDLE) && !reset && (bus.i_req || bus.d_req);
    assign win   = gnt_oh[1] ? REQ_D : REQ_I;

`ifdef MEM_ARB_RR_EN
    req_id_e last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_I;
        end else if (issue) begin
            last_q <= win;
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = REQ_I;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 2'd0;
            owner <= REQ_I;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_nxt     = owner;
        bus.i_gnt     = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.i_rvalid  = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.i_rdata   = 32'h0;
        bus.d_rdata   = 32'h0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;

        case (state)
            IDLE: begin
                if (issue) begin
                    bus.i_gnt     = gnt_oh[0];
                    bus.d_gnt     = gnt_oh[1];
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = gnt_oh[1] & bus.d_we;
                    bus.mem_addr  = word_align(gnt_oh[1] ? bus.d_addr : bus.i_addr);
                    bus.mem_wdata = gnt_oh[1] ? bus.d_wdata : 32'h0;
                    owner_nxt     = win;
                    if (MEM_LAT == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RESP: begin
                // A reset landing on the response cycle abandons the transaction silently.
                if (!reset) begin
                    if (owner == REQ_D) begin
                        bus.d_rvalid = 1'b1;
                        bus.d_rdata  = bus.mem_rdata;
                    end else begin
                        bus.i_rvalid = 1'b1;
                        bus.i_rdata  = bus.mem_rdata;
                    end
                end
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3
module tb_mem_arbiter;

    localparam logic [31:0] NOISE = 32'hA5A5_5A5A;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic reset_b;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] last_rd_a = 32'h0;

    exp_t sbq_a[$];
    exp_t sbq_b[$];

    logic [31:0] ref_mem [0:127];
    bit          ref_w   [0:127];
    logic [31:0] mem_a   [0:63];
    bit          mw_a    [0:63];
    logic [31:0] mem_b   [0:63];
    bit          mw_b    [0:63];
    logic [31:0] rd_a = NOISE;
    logic [31:0] pipe_b [0:2];

    mem_arbiter_if ifa ();
    mem_arbiter_if ifb ();

    mem_arbiter #(.MEM_LAT(1)) dut_a (.clk(clk), .reset(reset),   .bus(ifa));
    mem_arbiter #(.MEM_LAT(3)) dut_b (.clk(clk), .reset(reset_b), .bus(ifb));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    assign ifa.mem_rdata = rd_a;
    assign ifb.mem_rdata = pipe_b[2];

    // Memory models: write on the issue edge; read data appears MEM_LAT cycles later, noise otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_a <= NOISE;
        if (ifa.mem_en) begin
            if (ifa.mem_we) begin
                mem_a[ifa.mem_addr[7:2]] <= ifa.mem_wdata;
                mw_a[ifa.mem_addr[7:2]]  <= 1'b1;
            end else begin
                rd_a <= mw_a[ifa.mem_addr[7:2]] ? mem_a[ifa.mem_addr[7:2]] : init_word(int'(ifa.mem_addr[7:2]));
            end
        end
        pipe_b[0] <= NOISE;
        if (ifb.mem_en) begin
            if (ifb.mem_we) begin
                mem_b[ifb.mem_addr[7:2]] <= ifb.mem_wdata;
                mw_b[ifb.mem_addr[7:2]]  <= 1'b1;
            end else begin
                pipe_b[0] <= mw_b[ifb.mem_addr[7:2]] ? mem_b[ifb.mem_addr[7:2]] : init_word(int'(ifb.mem_addr[7:2]));
            end
        end
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mon(input bit b, input int lat, input logic ig, input logic dg, input logic dwe,
                       input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                       input logic me, input logic mwe, input logic [31:0] ma,
                       input logic irv, input logic drv, input logic [31:0] ird, input logic [31:0] drd);
        exp_t        e;
        int          idx;
        logic [31:0] addr;
        chk("single_gnt", 32'(ig & dg), 32'h0);
        if (ig || dg) begin
            addr = dg ? da : ia;
            idx  = (b ? 64 : 0) + int'(addr[7:2]);
            chk("mem_en", 32'(me), 32'h1);
            chk("mem_addr", ma, addr & 32'hFFFF_FFFC);
            chk("mem_we", 32'(mwe), 32'(dg & dwe));
            e.is_d = dg;
            e.due  = cyc + lat;
            e.data = (dg && dwe) ? NOISE : (ref_w[idx] ? ref_mem[idx] : init_word(idx % 64));
            if (dg && dwe) begin
                ref_mem[idx] = dwd;
                ref_w[idx]   = 1'b1;
            end
            if (b) sbq_b.push_back(e); else sbq_a.push_back(e);
        end else begin
            chk("mem_en_quiet", 32'(me), 32'h0);
        end
        if (irv || drv) begin
            if ((b ? sbq_b.size() : sbq_a.size()) == 0) begin
                chk("rvalid_spurious", {30'h0, irv, drv}, 32'h0);
            end else begin
                e = b ? sbq_b.pop_front() : sbq_a.pop_front();
                chk("rvalid_port", 32'(drv), 32'(e.is_d));
                chk("rvalid_both", 32'(irv & drv), 32'h0);
                chk("rvalid_cycle", 32'(cyc), 32'(e.due));
                chk("rdata", drv ? drd : ird, e.data);
                chk("rdata_other", drv ? ird : drd, 32'h0);
                if (!b) last_rd_a = drv ? drd : ird;
            end
        end else begin
            chk("rdata_zero", ird | drd, 32'h0);
            if ((b ? sbq_b.size() : sbq_a.size()) != 0)
                chk("rvalid_missing", 32'(cyc < (b ? sbq_b[0].due : sbq_a[0].due)), 32'h1);
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0, 1, ifa.i_gnt, ifa.d_gnt, ifa.d_we, ifa.i_addr, ifa.d_addr, ifa.d_wdata,
            ifa.mem_en, ifa.mem_we, ifa.mem_addr, ifa.i_rvalid, ifa.d_rvalid, ifa.i_rdata, ifa.d_rdata);
        mon(1'b1, 3, ifb.i_gnt, ifb.d_gnt, ifb.d_we, ifb.i_addr, ifb.d_addr, ifb.d_wdata,
            ifb.mem_en, ifb.mem_we, ifb.mem_addr, ifb.i_rvalid, ifb.d_rvalid, ifb.i_rdata, ifb.d_rdata);
    end

    task automatic issue_a(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 1'b0;
        if (is_d) begin
            ifa.d_req = 1'b1; ifa.d_we = we; ifa.d_addr = addr; ifa.d_wdata = wdata;
        end else begin
            ifa.i_req = 1'b1; ifa.i_addr = addr;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (is_d ? ifa.d_gnt : ifa.i_gnt) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("gnt_wait", 32'(got), 32'h1);
        @(posedge clk); #1;
        ifa.i_req = 1'b0;
        ifa.d_req = 1'b0;
        ifa.d_we  = 1'b0;
    endtask

    task automatic drain(input bit b);
        for (int k = 0; k < 12; k++) begin
            if ((b ? sbq_b.size() : sbq_a.size()) == 0) break;
            @(posedge clk); #1;
        end
        chk("drain", 32'(b ? sbq_b.size() : sbq_a.size()), 32'h0);
    endtask

    initial begin
        int  t0;
        bit  exp_d;
        bit  got;
        reset = 1'b1;
        reset_b = 1'b1;
        ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_we = 0; ifa.d_addr = 0; ifa.d_wdata = 0;
        ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_we = 0; ifb.d_addr = 0; ifb.d_wdata = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; reset_b = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_i_gnt",    32'(ifa.i_gnt),    32'h0);
        chk("rst_d_gnt",    32'(ifa.d_gnt),    32'h0);
        chk("rst_i_rvalid", 32'(ifa.i_rvalid), 32'h0);
        chk("rst_d_rvalid", 32'(ifa.d_rvalid), 32'h0);
        chk("rst_mem_we",   32'(ifa.mem_we),   32'h0);
        chk("rst_i_rdata",  ifa.i_rdata,       32'h0);
        chk("rst_d_rdata",  ifa.d_rdata,       32'h0);
        @(posedge clk); #1;

        // Single fetch, then write followed by read-back of the same word
        issue_a(1'b0, 1'b0, 32'h10, 32'h0);
        drain(1'b0);
        chk("fetch_deadbeef", last_rd_a, 32'hDEAD_BEEF);
        issue_a(1'b1, 1'b1, 32'h23, 32'h1234_5678);
        drain(1'b0);
        issue_a(1'b0, 1'b0, 32'h20, 32'h0);
        drain(1'b0);
        chk("fetch_after_write", last_rd_a, 32'h1234_5678);

        // Fetch request raised during RESP and dropped before IDLE is never issued
        ifa.d_req = 1'b1; ifa.d_addr = 32'h44;
        @(negedge clk);
        chk("drop_d_gnt", 32'(ifa.d_gnt), 32'h1);
        @(posedge clk); #1;
        ifa.d_req = 1'b0; ifa.i_req = 1'b1; ifa.i_addr = 32'h48;
        @(negedge clk);
        chk("resp_no_i_gnt", 32'(ifa.i_gnt), 32'h0);
        @(posedge clk); #1;
        ifa.i_req = 1'b0;
        @(negedge clk);
        chk("drop_no_issue", 32'(ifa.mem_en), 32'h0);
        @(posedge clk); #1;
        drain(1'b0);

        // Both requesting every slot, starting from reset
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ifa.i_req = 1'b1; ifa.i_addr = 32'h30;
        ifa.d_req = 1'b1; ifa.d_addr = 32'h40; ifa.d_we = 1'b0;
        for (int s = 0; s < 6; s++) begin
`ifdef MEM_ARB_RR_EN
            exp_d = (s % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            got = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (ifa.i_gnt || ifa.d_gnt) begin
                    got = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            chk("tie_gnt_seen", 32'(got), 32'h1);
            chk("tie_d_gnt", 32'(ifa.d_gnt), 32'(exp_d));
            chk("tie_i_gnt", 32'(ifa.i_gnt), 32'(!exp_d));
            @(posedge clk); #1;
            if (exp_d) ifa.d_addr = ifa.d_addr + 32'h4;
            else       ifa.i_addr = ifa.i_addr + 32'h4;
        end
        ifa.i_req = 1'b0; ifa.d_req = 1'b0;
        drain(1'b0);

        // MEM_LAT=3: two WAIT cycles, rvalid at T+3, back-to-back grant at T+4
        ifb.i_req = 1'b1; ifb.i_addr = 32'h8;
        @(negedge clk);
        chk("lat3_gnt", 32'(ifb.i_gnt), 32'h1);
        t0 = cyc;
        @(posedge clk); #1;
        ifb.i_addr = 32'hC;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("lat3_busy_gnt", 32'(ifb.i_gnt), 32'h0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lat3_next_gnt", 32'(ifb.i_gnt), 32'h1);
        chk("lat3_spacing", 32'(cyc - t0), 32'h4);
        @(posedge clk); #1;
        ifb.i_req = 1'b0;
        drain(1'b1);

        // Reset while in WAIT abandons the read; a new request is granted right after release
        ifb.d_req = 1'b1; ifb.d_addr = 32'h14; ifb.d_we = 1'b0;
        @(negedge clk);
        chk("rstwait_gnt", 32'(ifb.d_gnt), 32'h1);
        @(posedge clk); #1;
        reset_b = 1'b1;
        sbq_b.delete();
        ifb.d_req = 1'b0;
        ifb.i_req = 1'b1; ifb.i_addr = 32'h18;
        @(negedge clk);
        chk("rst_hold_gnt", 32'(ifb.i_gnt), 32'h0);
        chk("rst_hold_rvalid", 32'(ifb.i_rvalid | ifb.d_rvalid), 32'h0);
        @(posedge clk); #1;
        reset_b = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(ifb.i_gnt), 32'h1);
        @(posedge clk); #1;
        ifb.i_req = 1'b0;
        drain(1'b1);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
